// File: rtl/cfu_sad_sequencer.sv
// CFU sequencer that accumulates a lane-masked sum of absolute byte differences.
// Define CFU_SAD_SATURATE_EN to make SAD accumulation saturate instead of wrapping.
module cfu_sad_sequencer #(
    parameter logic [3:0] LANE_MASK_RESET = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_payload_response_ok,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high; a raised valid holds its payload unchanged until that edge.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] FN_CLEAR      = 3'd0;
    localparam logic [2:0] FN_SAD        = 3'd1;
    localparam logic [2:0] FN_READ       = 3'd2;
    localparam logic [2:0] FN_READ_CLEAR = 3'd3;
    localparam logic [2:0] FN_SET_MASK   = 3'd4;
    localparam logic [2:0] FN_LOAD       = 3'd5;

    state_t      state, state_next;
    logic [31:0] acc;
    logic [3:0]  mask;
    logic [1:0]  lane_cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  func_q;
    logic        rsp_ok_q;
    logic [31:0] rsp_data_q;
    logic        cmd_fire;

    logic [7:0]  lane_a;
    logic [7:0]  lane_b;
    logic [7:0]  lane_diff;
    logic [31:0] lane_add;
    logic [31:0] acc_next;

    assign cmd_fire = cmd_valid && (state == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_payload_function_id == FN_SAD) ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                if (lane_cnt == 2'd3) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic; response payload comes straight from registers
    always_comb begin
        cmd_ready               = (state == ST_IDLE);
        rsp_valid               = (state == ST_RESP);
        rsp_payload_response_ok = rsp_ok_q;
        rsp_payload_outputs_0   = rsp_data_q;
        dbg_state               = state;
    end

    // One lane per BUSY cycle; masked lanes contribute zero but still take a cycle
    always_comb begin
        lane_a    = op_a[{lane_cnt, 3'b000} +: 8];
        lane_b    = op_b[{lane_cnt, 3'b000} +: 8];
        lane_diff = (lane_a >= lane_b) ? (lane_a - lane_b) : (lane_b - lane_a);
        lane_add  = mask[lane_cnt] ? {24'b0, lane_diff} : 32'd0;
    end

`ifdef CFU_SAD_SATURATE_EN
    logic [32:0] acc_sum;
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, lane_add};
        acc_next = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    end
`else
    always_comb begin
        acc_next = acc + lane_add;
    end
`endif

    // Datapath: command capture, accumulator, mask and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= 32'd0;
            mask       <= LANE_MASK_RESET;
            lane_cnt   <= 2'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            func_q     <= 3'd0;
            rsp_ok_q   <= 1'b0;
            rsp_data_q <= 32'd0;
        end else if (cmd_fire) begin
            op_a     <= cmd_payload_inputs_0;
            op_b     <= cmd_payload_inputs_1;
            func_q   <= cmd_payload_function_id;
            lane_cnt <= 2'd0;
            rsp_ok_q <= 1'b1;
            case (cmd_payload_function_id)
                FN_CLEAR: begin
                    acc        <= 32'd0;
                    rsp_data_q <= 32'd0;
                end
                FN_SAD: begin
                    rsp_data_q <= rsp_data_q;
                end
                FN_READ: begin
                    rsp_data_q <= acc;
                end
                FN_READ_CLEAR: begin
                    rsp_data_q <= acc;
                    acc        <= 32'd0;
                end
                FN_SET_MASK: begin
                    rsp_data_q <= {28'b0, mask};
                    mask       <= cmd_payload_inputs_0[3:0];
                end
                FN_LOAD: begin
                    acc        <= cmd_payload_inputs_0;
                    rsp_data_q <= cmd_payload_inputs_0;
                end
                default: begin
                    rsp_ok_q   <= 1'b0;
                    rsp_data_q <= 32'd0;
                end
            endcase
        end else if (state == ST_BUSY && func_q == FN_SAD) begin
            acc      <= acc_next;
            lane_cnt <= lane_cnt + 2'd1;
            if (lane_cnt == 2'd3) begin
                rsp_data_q <= acc_next;
                rsp_ok_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfu_sad_sequencer.sv
// Directed bench for cfu_sad_sequencer: each scenario task drives commands and
// compares responses against hand-computed values.
module tb_cfu_sad_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  fid = 3'd0;
    logic [31:0] in0 = 32'd0;
    logic [31:0] in1 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_ok;
    logic [31:0] rsp_data;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] r_data;
    logic        r_ok;
    int          r_lat;
    logic [31:0] wrap_exp;

    cfu_sad_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_ok),
        .rsp_payload_outputs_0   (rsp_data),
        .dbg_state               (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver: offer a command, return at the first negedge after acceptance
    task automatic start_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        fid = f;
        in0 = a;
        in1 = b;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        in0 = $urandom;
        in1 = $urandom;
        fid = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output logic ok, output int lat);
        start_cmd(f, a, b);
        wait_rsp(lat);
        data = rsp_data;
        ok = rsp_ok;
        finish_rsp();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
        checks++;
        if (rsp_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b exp 0", rsp_ok); end
        checks++;
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", rsp_data); end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_sad_basic();
        run_cmd(3'd0, 32'h1234_5678, 32'h9abc_def0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0 || r_ok !== 1'b1 || r_lat != 1) begin
            errors++; $display("FAIL clear_rsp: data %h ok %b lat %0d exp 0/1/1", r_data, r_ok, r_lat);
        end
        exp_q.push_back(32'h0000_0060);
        run_cmd(3'd1, 32'h1020_3040, 32'h2010_3000, r_data, r_ok, r_lat);
        exp = exp_q.pop_front();
        checks++;
        if (r_data !== exp) begin errors++; $display("FAIL sad_data: got %h exp %h", r_data, exp); end
        checks++;
        if (r_lat != 5) begin errors++; $display("FAIL sad_latency: got %0d exp 5", r_lat); end
        checks++;
        if (r_ok !== 1'b1) begin errors++; $display("FAIL sad_ok: got %b exp 1", r_ok); end
    endtask

    task automatic test_mask();
        run_cmd(3'd4, 32'h0000_0005, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_000F) begin errors++; $display("FAIL set_mask_prev: got %h exp 0000000f", r_data); end
        run_cmd(3'd0, 32'd0, 32'd0, r_data, r_ok, r_lat);
        run_cmd(3'd1, 32'h8080_8080, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_0100) begin errors++; $display("FAIL sad_mask5: got %h exp 00000100", r_data); end
        run_cmd(3'd4, 32'h0000_0000, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_0005) begin errors++; $display("FAIL set_mask_prev5: got %h exp 00000005", r_data); end
        run_cmd(3'd1, 32'hFFFF_FFFF, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_0100 || r_lat != 5) begin
            errors++; $display("FAIL sad_mask0: data %h lat %0d exp 00000100/5", r_data, r_lat);
        end
        run_cmd(3'd4, 32'h0000_000F, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_0000) begin errors++; $display("FAIL set_mask_prev0: got %h exp 0", r_data); end
    endtask

    task automatic test_wrap();
`ifdef CFU_SAD_SATURATE_EN
        wrap_exp = 32'hFFFF_FFFF;
`else
        wrap_exp = 32'h0000_0100;
`endif
        run_cmd(3'd5, 32'hFFFF_FF00, 32'h1111_1111, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'hFFFF_FF00 || r_lat != 1) begin
            errors++; $display("FAIL load_rsp: data %h lat %0d exp ffffff00/1", r_data, r_lat);
        end
        run_cmd(3'd1, 32'h8080_8080, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== wrap_exp) begin errors++; $display("FAIL sad_overflow: got %h exp %h", r_data, wrap_exp); end
    endtask

    task automatic test_illegal();
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== wrap_exp || r_ok !== 1'b1) begin
            errors++; $display("FAIL read_before: data %h ok %b exp %h/1", r_data, r_ok, wrap_exp);
        end
        run_cmd(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0 || r_ok !== 1'b0 || r_lat != 1) begin
            errors++; $display("FAIL fn6_rsp: data %h ok %b lat %0d exp 0/0/1", r_data, r_ok, r_lat);
        end
        run_cmd(3'd7, 32'h0000_0003, 32'h0000_0001, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0 || r_ok !== 1'b0 || r_lat != 1) begin
            errors++; $display("FAIL fn7_rsp: data %h ok %b lat %0d exp 0/0/1", r_data, r_ok, r_lat);
        end
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== wrap_exp) begin errors++; $display("FAIL read_after_illegal: got %h exp %h", r_data, wrap_exp); end
    endtask

    task automatic test_hold();
        int bad;
        run_cmd(3'd0, 32'd0, 32'd0, r_data, r_ok, r_lat);
        start_cmd(3'd1, 32'h1020_3040, 32'h2010_3000);
        wait_rsp(r_lat);
        checks++;
        if (r_lat != 5 || rsp_data !== 32'h0000_0060) begin
            errors++; $display("FAIL hold_first: data %h lat %0d exp 00000060/5", rsp_data, r_lat);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            fid = 3'($urandom_range(0, 7));
            in0 = $urandom;
            in1 = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0060 || rsp_ok !== 1'b1 || cmd_ready !== 1'b0) begin
                bad++;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles exp 0", bad); end
        finish_rsp();
        run_cmd(3'd3, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_0060) begin errors++; $display("FAIL read_clear: got %h exp 00000060", r_data); end
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0) begin errors++; $display("FAIL read_after_clear: got %h exp 0", r_data); end
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd5, 32'hDEAD_BEEF, 32'd0, r_data, r_ok, r_lat);
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'hDEAD_BEEF || r_lat != 1) begin
            errors++; $display("FAIL b2b_read: data %h lat %0d exp deadbeef/1", r_data, r_lat);
        end
        run_cmd(3'd3, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_read_clear: got %h exp deadbeef", r_data); end
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0) begin errors++; $display("FAIL b2b_read_zero: got %h exp 0", r_data); end
    endtask

    task automatic test_reset_busy();
        int seen;
        run_cmd(3'd5, 32'h0000_1234, 32'd0, r_data, r_ok, r_lat);
        run_cmd(3'd4, 32'h0000_0003, 32'd0, r_data, r_ok, r_lat);
        start_cmd(3'd1, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL busy_state: got %0d exp 1", dbg_state); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL mid_busy_reset: rsp_valid %b cmd_ready %b state %0d exp 0/1/0",
                               rsp_valid, cmd_ready, dbg_state);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL discarded_rsp: %0d valid cycles exp 0", seen); end
        run_cmd(3'd2, 32'd0, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'd0) begin errors++; $display("FAIL read_after_reset: got %h exp 0", r_data); end
        run_cmd(3'd4, 32'h0000_000A, 32'd0, r_data, r_ok, r_lat);
        checks++;
        if (r_data !== 32'h0000_000F) begin errors++; $display("FAIL mask_after_reset: got %h exp 0000000f", r_data); end
    endtask

    initial begin
        test_reset();
        test_sad_basic();
        test_mask();
        test_wrap();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
